// File: rtl/retire_trace_pipe_pkg.sv
// Shared types for the retirement trace shadow pipeline: instruction class,
// per-stage shadow entry, and the record handed to the retirement checker.
package trace_pkg;

    localparam int unsigned TRACE_XLEN    = 32;
    localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;
    localparam logic [31:0] EXIT_CODE     = 32'h0000_000A;

    typedef enum logic [1:0] {
        ITYPE_R    = 2'd0,
        ITYPE_I    = 2'd1,
        ITYPE_J    = 2'd2,
        ITYPE_NONE = 2'd3
    } instr_type_t;

    typedef struct packed {
        logic                  valid;
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] instr;
        instr_type_t           itype;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] rs_val;
        logic [TRACE_XLEN-1:0] rt_val;
        logic [TRACE_XLEN-1:0] rd_val;
    } stage_t;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] instr;
        instr_type_t           itype;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] rs_val;
        logic [TRACE_XLEN-1:0] rt_val;
        logic [TRACE_XLEN-1:0] dest;
    } trace_rec_t;

    // Non-writing instructions report the snooped destination register instead.
    function automatic logic [TRACE_XLEN-1:0] retire_dest(
        input stage_t                s,
        input logic                  reg_wr,
        input logic [TRACE_XLEN-1:0] wr_data
    );
        if (reg_wr) return wr_data;
        return (s.itype == ITYPE_R) ? s.rd_val : s.rt_val;
    endfunction

endpackage

// File: rtl/retire_trace_pipe_fifo.sv
// Registered ready/valid FIFO for trace records; no write-to-read bypass.
// A push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             overflow
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             overflow_q;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full      = (count_q == FULL_CNT);
    assign pop_valid = (count_q != '0);
    assign do_pop    = pop_valid & pop_ready;
    assign do_push   = push_valid & (~full | do_pop);
    assign pop_data  = mem_q[rd_ptr_q];
    assign overflow  = overflow_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_valid && full && !do_pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/retire_trace_pipe.sv
// Instruction-trace shadow pipeline: mirrors the core's stages, snoops operand
// values at the capture stage and queues one record per retired instruction.
module retire_trace_pipe
    import trace_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = 4,
    parameter int unsigned CAPTURE_STAGE = 1,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned XLEN          = TRACE_XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_instr,
    input  instr_type_t           in_type,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [NUM_STAGES-1:0] stall,
    input  logic [NUM_STAGES-1:0] flush,
    output logic [4:0]            cap_rs,
    output logic [4:0]            cap_rt,
    output logic [4:0]            cap_rd,
    input  logic [XLEN-1:0]       cap_rs_val,
    input  logic [XLEN-1:0]       cap_rt_val,
    input  logic [XLEN-1:0]       cap_rd_val,
    input  logic                  wb_retire,
    input  logic                  wb_reg_wr,
    input  logic [XLEN-1:0]       wb_wr_data,
    input  logic [XLEN-1:0]       v0_val,
    output logic                  trc_valid,
    input  logic                  trc_ready,
    output trace_rec_t            trc_rec,
    output logic                  overflow,
    output logic                  err_bubble,
    output logic                  err_type,
    output logic                  sim_done
);

    localparam int unsigned LAST = NUM_STAGES - 1;

    stage_t                stage_w [NUM_STAGES];
    logic [NUM_STAGES-1:0] hold;

    // A stage holds whenever any stage at or downstream of it stalls.
    always_comb begin
        hold       = '0;
        hold[LAST] = stall[LAST];
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            hold[LAST-k] = hold[LAST-k+1] | stall[LAST-k];
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        stage_t st_q;
        stage_t st_d;
        stage_t up;

        if (g == 0) begin : g_head
            always_comb begin
                up       = '0;
                up.valid = in_valid;
                up.pc    = in_pc;
                up.instr = in_instr;
                up.itype = in_type;
                up.rs    = in_rs;
                up.rt    = in_rt;
                up.rd    = in_rd;
            end
        end else begin : g_body
            // Flushed upstream content is killed rather than passed on.
            always_comb begin
                up = stage_w[g-1];
                if (hold[g-1] || flush[g-1]) up.valid = 1'b0;
                if (g == CAPTURE_STAGE + 1) begin
                    up.rs_val = cap_rs_val;
                    up.rt_val = cap_rt_val;
                    up.rd_val = cap_rd_val;
                end
            end
        end

        always_comb begin
            st_d = st_q;
            if (flush[g]) begin
                st_d.valid = 1'b0;
            end else if (hold[g]) begin
                if (g == LAST && wb_retire) st_d.valid = 1'b0;
            end else begin
                st_d = up;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) st_q <= '0;
            else       st_q <= st_d;
        end

        assign stage_w[g] = st_q;
    end

    assign cap_rs = stage_w[CAPTURE_STAGE].rs;
    assign cap_rt = stage_w[CAPTURE_STAGE].rt;
    assign cap_rd = stage_w[CAPTURE_STAGE].rd;

    stage_t     last;
    logic       push;
    trace_rec_t push_rec;
    logic       err_bubble_q;
    logic       err_type_q;
    logic       sim_done_q;

    assign last = stage_w[LAST];
    assign push = wb_retire & last.valid;

    always_comb begin
        push_rec        = '0;
        push_rec.pc     = last.pc;
        push_rec.instr  = last.instr;
        push_rec.itype  = last.itype;
        push_rec.rs     = last.rs;
        push_rec.rt     = last.rt;
        push_rec.rd     = last.rd;
        push_rec.rs_val = last.rs_val;
        push_rec.rt_val = last.rt_val;
        push_rec.dest   = retire_dest(last, wb_reg_wr, wb_wr_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_bubble_q <= 1'b0;
            err_type_q   <= 1'b0;
            sim_done_q   <= 1'b0;
        end else begin
            if (wb_retire && !last.valid) err_bubble_q <= 1'b1;
            if (push && (last.itype == ITYPE_J || last.itype == ITYPE_NONE)) err_type_q <= 1'b1;
            if (push && last.instr == SYSCALL_INSTR && v0_val == EXIT_CODE) sim_done_q <= 1'b1;
        end
    end

    assign err_bubble = err_bubble_q;
    assign err_type   = err_type_q;
    assign sim_done   = sim_done_q;

    logic [$bits(trace_rec_t)-1:0] head_bits;

    trace_fifo #(
        .WIDTH($bits(trace_rec_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_valid(push),
        .push_data (push_rec),
        .pop_valid (trc_valid),
        .pop_ready (trc_ready),
        .pop_data  (head_bits),
        .overflow  (overflow)
    );

    assign trc_rec = trace_rec_t'(head_bits);

endmodule

// File: tb/tb_retire_trace_pipe.sv
// Bench for retire_trace_pipe: instruction-id reference model with a record
// queue, directed scenarios with literal expectations, then randomized traffic.
module tb_retire_trace_pipe;
    import trace_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned C = 1;
    localparam int unsigned D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_valid, wb_retire, wb_reg_wr, trc_valid, trc_ready;
    logic overflow, err_bubble, err_type, sim_done;
    logic [31:0] in_pc, in_instr, cap_rs_val, cap_rt_val, cap_rd_val, wb_wr_data, v0_val;
    instr_type_t in_type;
    logic [4:0] in_rs, in_rt, in_rd, cap_rs, cap_rt, cap_rd;
    logic [N-1:0] stall, flush;
    trace_rec_t trc_rec;

    retire_trace_pipe #(
        .NUM_STAGES(N), .CAPTURE_STAGE(C), .FIFO_DEPTH(D), .XLEN(32)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_type(in_type), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .stall(stall), .flush(flush), .cap_rs(cap_rs), .cap_rt(cap_rt), .cap_rd(cap_rd),
        .cap_rs_val(cap_rs_val), .cap_rt_val(cap_rt_val), .cap_rd_val(cap_rd_val),
        .wb_retire(wb_retire), .wb_reg_wr(wb_reg_wr), .wb_wr_data(wb_wr_data), .v0_val(v0_val),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_rec(trc_rec),
        .overflow(overflow), .err_bubble(err_bubble), .err_type(err_type), .sim_done(sim_done)
    );

    typedef struct {
        logic [31:0] pc, instr;
        instr_type_t typ;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsv, rtv, rdv;
    } ent_t;

    ent_t        tbl[$];
    int          m_id[N];
    trace_rec_t  fq[$];
    bit          m_ovf, m_bub, m_typ, m_done;
    bit          started, auto_retire, snoop_rand;
    int          checks, errors;
    logic [31:0] got[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each stage slot holds an instruction id (index into tbl) or -1 for a bubble.
    task automatic model_update();
        bit         h[N];
        int         nid[N];
        bit         do_push;
        ent_t       e;
        trace_rec_t r;
        if (reset) begin
            for (int i = 0; i < N; i++) m_id[i] = -1;
            fq.delete();
            m_ovf = 0; m_bub = 0; m_typ = 0; m_done = 0;
            return;
        end
        do_push = 0;
        if (wb_retire) begin
            if (m_id[N-1] < 0) m_bub = 1;
            else begin
                e = tbl[m_id[N-1]];
                r.pc = e.pc; r.instr = e.instr; r.itype = e.typ;
                r.rs = e.rs; r.rt = e.rt; r.rd = e.rd;
                r.rs_val = e.rsv; r.rt_val = e.rtv;
                r.dest = wb_reg_wr ? wb_wr_data : ((e.typ == ITYPE_R) ? e.rdv : e.rtv);
                if (e.typ == ITYPE_J || e.typ == ITYPE_NONE) m_typ = 1;
                if (e.instr == 32'h0000_000C && v0_val == 32'h0000_000A) m_done = 1;
                do_push = 1;
            end
        end
        if (trc_ready && fq.size() > 0) void'(fq.pop_front());
        if (do_push) begin
            if (fq.size() < D) fq.push_back(r);
            else m_ovf = 1;
        end
        for (int i = 0; i < N; i++) h[i] = ((stall >> i) != 0);
        for (int i = 0; i < N; i++) begin
            if (flush[i]) nid[i] = -1;
            else if (h[i]) nid[i] = (i == N-1 && wb_retire) ? -1 : m_id[i];
            else if (i == 0) begin
                if (in_valid) begin
                    e.pc = in_pc; e.instr = in_instr; e.typ = in_type;
                    e.rs = in_rs; e.rt = in_rt; e.rd = in_rd;
                    e.rsv = '0; e.rtv = '0; e.rdv = '0;
                    tbl.push_back(e);
                    nid[0] = tbl.size() - 1;
                end else nid[0] = -1;
            end else begin
                nid[i] = (h[i-1] || flush[i-1]) ? -1 : m_id[i-1];
                if (i == C + 1 && nid[i] >= 0) begin
                    e = tbl[nid[i]];
                    e.rsv = cap_rs_val; e.rtv = cap_rt_val; e.rdv = cap_rd_val;
                    tbl[nid[i]] = e;
                end
            end
        end
        for (int i = 0; i < N; i++) m_id[i] = nid[i];
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("trc_valid", trc_valid, fq.size() > 0);
            if (trc_valid && fq.size() > 0) chk("trc_rec", trc_rec, fq[0]);
            chk("overflow", overflow, m_ovf);
            chk("err_bubble", err_bubble, m_bub);
            chk("err_type", err_type, m_typ);
            chk("sim_done", sim_done, m_done);
            if (m_id[C] >= 0) begin
                chk("cap_rs", cap_rs, tbl[m_id[C]].rs);
                chk("cap_rt", cap_rt, tbl[m_id[C]].rt);
                chk("cap_rd", cap_rd, tbl[m_id[C]].rd);
            end
        end
    end

    task automatic step();
        if (auto_retire) wb_retire = (m_id[N-1] >= 0);
        if (!snoop_rand && m_id[C] >= 0) begin
            cap_rs_val = 32'hA000_0000 | 32'(tbl[m_id[C]].rs);
            cap_rt_val = 32'hA000_0000 | 32'(tbl[m_id[C]].rt);
            cap_rd_val = 32'hA000_0000 | 32'(tbl[m_id[C]].rd);
        end else begin
            cap_rs_val = $urandom; cap_rt_val = $urandom; cap_rd_val = $urandom;
        end
        @(posedge clk);
        model_update();
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step_collect();
        if (trc_valid && trc_ready) got.push_back(trc_rec.pc);
        step();
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input instr_type_t t,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        in_valid = 1'b1; in_pc = pc; in_instr = instr; in_type = t;
        in_rs = rs; in_rt = rt; in_rd = rd;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = '0; flush = '0; in_valid = 1'b0; wb_retire = 1'b0;
        step(); step();
        reset = 1'b0;
        started = 1;
    endtask

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; started = 0; auto_retire = 1; snoop_rand = 0;
        for (int i = 0; i < N; i++) m_id[i] = -1;
        reset = 1'b1; in_valid = 0; in_pc = '0; in_instr = '0; in_type = ITYPE_R;
        in_rs = '0; in_rt = '0; in_rd = '0; stall = '0; flush = '0;
        cap_rs_val = '0; cap_rt_val = '0; cap_rd_val = '0;
        wb_retire = 0; wb_reg_wr = 0; wb_wr_data = '0; v0_val = '0; trc_ready = 1;
        #1;
        do_reset();
        chk("rst_valid", trc_valid, 1'b0);
        chk("rst_cap", {cap_rs, cap_rt, cap_rd}, 15'h0);
        chk("rst_flags", {overflow, err_bubble, err_type, sim_done}, 4'b0000);

        // Single R-type add, no stalls.
        wb_reg_wr = 1; wb_wr_data = 32'h0000_0055;
        issue(32'h100, 32'h0022_1820, ITYPE_R, 5'd1, 5'd2, 5'd3);
        for (int k = 1; k <= N + 1; k++) begin
            step();
            if (k < N + 1) chk("lat_early", trc_valid, 1'b0);
        end
        chk("lat_valid", trc_valid, 1'b1);
        chk("r_pc", trc_rec.pc, 32'h100);
        chk("r_dest", trc_rec.dest, 32'h55);
        chk("r_rsval", trc_rec.rs_val, 32'hA000_0001);
        chk("r_rtval", trc_rec.rt_val, 32'hA000_0002);
        step();
        chk("r_popped", trc_valid, 1'b0);

        // Stall stage 2 for two cycles mid-stream.
        got.delete();
        begin
            int k;
            k = 0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                stall = (cyc == 3 || cyc == 4) ? 4'b0100 : 4'b0000;
                if (k < 6) issue(32'h200 + 32'(4 * k), 32'h0100_0000 + 32'(k), ITYPE_I, 5'(k), 5'd6, 5'd7);
                step_collect();
                if (k < 6 && stall == 4'b0000) k++;
            end
        end
        stall = '0;
        chk("stall_cnt", got.size(), 6);
        for (int i = 0; i < 6; i++) if (i < got.size()) chk("stall_order", got[i], 32'h200 + 32'(4 * i));

        // Flush the two youngest of four in flight.
        do_reset();
        got.delete();
        for (int k = 0; k < 4; k++) begin
            issue(32'h300 + 32'(4 * k), 32'h0200_0000, ITYPE_R, 5'd8, 5'd9, 5'd10);
            step_collect();
        end
        flush = 4'b0011;
        step_collect();
        flush = '0;
        for (int k = 0; k < 10; k++) step_collect();
        chk("flush_cnt", got.size(), 2);
        if (got.size() >= 2) begin
            chk("flush_rec0", got[0], 32'h300);
            chk("flush_rec1", got[1], 32'h304);
        end

        // Nine retires into an 8-entry FIFO with the consumer stalled.
        do_reset();
        trc_ready = 0;
        for (int k = 0; k < 9; k++) begin
            issue(32'h400 + 32'(4 * k), 32'h0300_0000, ITYPE_I, 5'd1, 5'd2, 5'd3);
            step();
        end
        for (int k = 0; k < 6; k++) step();
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_valid", trc_valid, 1'b1);
        trc_ready = 1;
        got.delete();
        for (int k = 0; k < 12; k++) step_collect();
        chk("ovf_drain_cnt", got.size(), 8);
        for (int i = 0; i < 8; i++) if (i < got.size()) chk("ovf_order", got[i], 32'h400 + 32'(4 * i));

        // Retire on an empty last stage.
        do_reset();
        auto_retire = 0; wb_retire = 1;
        step();
        wb_retire = 0; auto_retire = 1;
        chk("bub_flag", err_bubble, 1'b1);
        chk("bub_others", {overflow, err_type, sim_done}, 3'b000);

        // J-type retire.
        do_reset();
        issue(32'h500, 32'h0800_0040, ITYPE_J, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 6; k++) step();
        chk("jtype_flag", err_type, 1'b1);
        chk("jtype_others", {overflow, err_bubble, sim_done}, 3'b000);

        // Exit syscall with v0 == 10, then with v0 == 9.
        do_reset();
        v0_val = 32'hA;
        issue(32'h600, 32'h0000_000C, ITYPE_R, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < N; k++) step();
        chk("done_early", sim_done, 1'b0);
        step();
        chk("done_set", sim_done, 1'b1);
        do_reset();
        v0_val = 32'h9;
        issue(32'h600, 32'h0000_000C, ITYPE_R, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 8; k++) step();
        chk("done_wrong_v0", sim_done, 1'b0);

        // Reset with records queued and instructions in flight.
        trc_ready = 0;
        for (int k = 0; k < 3; k++) begin
            issue(32'h700 + 32'(4 * k), 32'h0400_0000, ITYPE_I, 5'd4, 5'd5, 5'd6);
            step();
        end
        for (int k = 0; k < 3; k++) step();
        do_reset();
        chk("rst_mid_valid", trc_valid, 1'b0);
        trc_ready = 1;
        for (int k = 0; k < 6; k++) step();
        chk("rst_mid_quiet", trc_valid, 1'b0);

        // Randomized traffic against the model.
        snoop_rand = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset();
            stall = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            flush = ($urandom_range(0, 24) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 9) < 7)
                issue($urandom, $urandom, instr_type_t'(2'($urandom_range(0, 3))),
                      5'($urandom), 5'($urandom), 5'($urandom));
            trc_ready = ($urandom_range(0, 3) != 0);
            wb_reg_wr = 1'($urandom);
            wb_wr_data = $urandom;
            v0_val = ($urandom_range(0, 3) == 0) ? 32'hA : $urandom;
            auto_retire = ($urandom_range(0, 19) != 0);
            if (!auto_retire) wb_retire = 1'($urandom);
            step();
        end
        auto_retire = 1; stall = '0; flush = '0; trc_ready = 1;
        for (int k = 0; k < 20; k++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
